// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline buffer: valid/ready handshake with a 2-entry skid buffer and branch flush.
// Optional stall counter enabled by defining ID_EXE_STALL_CNT_EN.
module id_exe_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_val_rn,
    input  logic [DATA_W-1:0] in_val_rm,
    input  logic [11:0]       in_shift_operand,
    input  logic              in_imm,
    input  logic [3:0]        in_exe_cmd,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic              in_wb_en,
    input  logic              in_s,
    input  logic              in_b,
    input  logic [3:0]        in_status,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [REG_AW-1:0] in_src1,
    input  logic [REG_AW-1:0] in_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_val_rn,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [11:0]       out_shift_operand,
    output logic              out_imm,
    output logic [3:0]        out_exe_cmd,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic              out_wb_en,
    output logic              out_s,
    output logic              out_b,
    output logic [3:0]        out_status,
    output logic [REG_AW-1:0] out_dest,
    output logic [REG_AW-1:0] out_src1,
    output logic [REG_AW-1:0] out_src2,
    output logic              out_select,
`ifdef ID_EXE_STALL_CNT_EN
    input  logic              stall_cnt_clr,
    output logic [31:0]       stall_cnt,
`endif
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] valRn;
        logic [DATA_W-1:0] valRm;
        logic [11:0]       shiftOperand;
        logic              imm;
        logic [3:0]        exeCmd;
        logic              memREn;
        logic              memWEn;
        logic              wbEn;
        logic              s;
        logic              b;
        logic [3:0]        status;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
    } bundle_t;

    bundle_t inBundle;
    bundle_t mainData_q, mainData_d;
    bundle_t skidData_q, skidData_d;
    logic    mainValid_q, mainValid_d;
    logic    skidValid_q, skidValid_d;
    logic    accept;
    logic    drain;

    always_comb begin
        inBundle.pc           = in_pc;
        inBundle.valRn        = in_val_rn;
        inBundle.valRm        = in_val_rm;
        inBundle.shiftOperand = in_shift_operand;
        inBundle.imm          = in_imm;
        inBundle.exeCmd       = in_exe_cmd;
        inBundle.memREn       = in_mem_r_en;
        inBundle.memWEn       = in_mem_w_en;
        inBundle.wbEn         = in_wb_en;
        inBundle.s            = in_s;
        inBundle.b            = in_b;
        inBundle.status       = in_status;
        inBundle.dest         = in_dest;
        inBundle.src1         = in_src1;
        inBundle.src2         = in_src2;
    end

    // in_ready depends only on registered state and reset, never on out_ready.
    assign in_ready = rst & ~skidValid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = mainValid_q & out_ready;

    always_comb begin
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        mainData_d  = mainData_q;
        skidData_d  = skidData_q;
        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (skidValid_q && drain) begin
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
        end else if (!skidValid_q && accept && (!mainValid_q || drain)) begin
            mainData_d  = inBundle;
            mainValid_d = 1'b1;
        end else if (!skidValid_q && accept && mainValid_q && !drain) begin
            skidData_d  = inBundle;
            skidValid_d = 1'b1;
        end else if (!skidValid_q && drain) begin
            mainValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            mainData_q  <= '0;
            skidData_q  <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            mainData_q  <= mainData_d;
            skidData_q  <= skidData_d;
        end
    end

    assign out_valid         = mainValid_q;
    assign out_pc            = mainData_q.pc;
    assign out_val_rn        = mainData_q.valRn;
    assign out_val_rm        = mainData_q.valRm;
    assign out_shift_operand = mainData_q.shiftOperand;
    assign out_imm           = mainData_q.imm;
    assign out_exe_cmd       = mainData_q.exeCmd;
    assign out_status        = mainData_q.status;
    assign out_dest          = mainData_q.dest;
    assign out_src1          = mainData_q.src1;
    assign out_src2          = mainData_q.src2;

    // State-changing controls are masked so a bubble can never write anything.
    assign out_mem_r_en = mainValid_q & mainData_q.memREn;
    assign out_mem_w_en = mainValid_q & mainData_q.memWEn;
    assign out_wb_en    = mainValid_q & mainData_q.wbEn;
    assign out_s        = mainValid_q & mainData_q.s;
    assign out_b        = mainValid_q & mainData_q.b;
    assign out_select   = mainValid_q & (mainData_q.memREn | mainData_q.memWEn);

    assign occupancy = 2'(mainValid_q) + 2'(skidValid_q);

    skidImpliesMain: assert property (@(posedge clk) disable iff (!rst) skidValid_q |-> mainValid_q);

`ifdef ID_EXE_STALL_CNT_EN
    logic [31:0] stallCnt_q, stallCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall_cnt_clr) begin
            stallCnt_d = '0;
        end else if (mainValid_q && !out_ready && stallCnt_q != 32'hFFFF_FFFF) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: a FIFO-queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_id_exe_pipe_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] valRn;
        logic [31:0] valRm;
        logic [11:0] shiftOperand;
        logic        imm;
        logic [3:0]  exeCmd;
        logic        memREn;
        logic        memWEn;
        logic        wbEn;
        logic        s;
        logic        b;
        logic [3:0]  status;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    bundle_t     inB = '0;
    bundle_t     outB;
    logic        in_ready, out_valid, out_select;
    logic [1:0]  occupancy;
`ifdef ID_EXE_STALL_CNT_EN
    logic        stall_cnt_clr = 1'b0;
    logic [31:0] stall_cnt;
    logic [31:0] modelCnt = '0;
`endif

    int errors = 0;
    int checks = 0;
    bit compareEn = 1'b0;
    bundle_t mq[$];

    always #5 clk = ~clk;

    id_exe_pipe_reg #(.DATA_W(32), .REG_AW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(inB.pc), .in_val_rn(inB.valRn), .in_val_rm(inB.valRm),
        .in_shift_operand(inB.shiftOperand), .in_imm(inB.imm), .in_exe_cmd(inB.exeCmd),
        .in_mem_r_en(inB.memREn), .in_mem_w_en(inB.memWEn), .in_wb_en(inB.wbEn),
        .in_s(inB.s), .in_b(inB.b), .in_status(inB.status),
        .in_dest(inB.dest), .in_src1(inB.src1), .in_src2(inB.src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(outB.pc), .out_val_rn(outB.valRn), .out_val_rm(outB.valRm),
        .out_shift_operand(outB.shiftOperand), .out_imm(outB.imm), .out_exe_cmd(outB.exeCmd),
        .out_mem_r_en(outB.memREn), .out_mem_w_en(outB.memWEn), .out_wb_en(outB.wbEn),
        .out_s(outB.s), .out_b(outB.b), .out_status(outB.status),
        .out_dest(outB.dest), .out_src1(outB.src1), .out_src2(outB.src2),
        .out_select(out_select),
`ifdef ID_EXE_STALL_CNT_EN
        .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt),
`endif
        .occupancy(occupancy)
    );

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t mkB(input logic [31:0] pc);
        bundle_t b;
        b.pc           = pc;
        b.valRn        = pc ^ 32'h1111_0000;
        b.valRm        = ~pc;
        b.shiftOperand = pc[11:0] ^ 12'h5A5;
        b.imm          = pc[2];
        b.exeCmd       = pc[5:2];
        b.memREn       = 1'b0;
        b.memWEn       = 1'b0;
        b.wbEn         = 1'b1;
        b.s            = pc[3];
        b.b            = pc[4];
        b.status       = pc[7:4];
        b.dest         = pc[5:2];
        b.src1         = pc[6:3];
        b.src2         = pc[7:4];
        return b;
    endfunction

    task automatic applyStimulus(input logic v, input bundle_t b, input logic ordy, input logic fl);
        in_valid  = v;
        inB       = b;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Model: the buffer is a FIFO of at most two bundles; reset and flush empty it.
    always @(posedge clk) begin
        bit acc, drn;
        acc = in_valid && rst && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
`ifdef ID_EXE_STALL_CNT_EN
        if (!rst || stall_cnt_clr) modelCnt <= '0;
        else if (mq.size() > 0 && !out_ready && modelCnt != 32'hFFFF_FFFF) modelCnt <= modelCnt + 1;
`endif
        if (!rst || flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(inB);
        end
    end

    always @(negedge clk) begin
        if (compareEn) begin
            bit      has;
            bundle_t hd;
            has = mq.size() > 0;
            hd  = has ? mq[0] : '0;
            checkOutput("in_ready", 160'(in_ready), 160'(rst && mq.size() < 2));
            checkOutput("out_valid", 160'(out_valid), 160'(has));
            checkOutput("occupancy", 160'(occupancy), 160'(mq.size()));
            checkOutput("out_wb_en", 160'(outB.wbEn), 160'(has & hd.wbEn));
            checkOutput("out_mem_r_en", 160'(outB.memREn), 160'(has & hd.memREn));
            checkOutput("out_mem_w_en", 160'(outB.memWEn), 160'(has & hd.memWEn));
            checkOutput("out_s", 160'(outB.s), 160'(has & hd.s));
            checkOutput("out_b", 160'(outB.b), 160'(has & hd.b));
            checkOutput("out_select", 160'(out_select), 160'(has & (hd.memREn | hd.memWEn)));
            if (has) checkOutput("out_bundle", 160'(outB), 160'(hd));
`ifdef ID_EXE_STALL_CNT_EN
            checkOutput("stall_cnt", 160'(stall_cnt), 160'(modelCnt));
`endif
        end
    end

    initial begin
        @(posedge clk);
        compareEn = 1'b1;
    end

    initial begin
        bundle_t b;

        // Reset held low with traffic offered.
        rst = 1'b0;
        applyStimulus(1'b1, mkB(32'h99), 1'b1, 1'b0);
        applyStimulus(1'b1, mkB(32'h9C), 1'b1, 1'b0);
        checkOutput("rst_out_valid", 160'(out_valid), 160'(0));
        checkOutput("rst_in_ready", 160'(in_ready), 160'(0));
        checkOutput("rst_occupancy", 160'(occupancy), 160'(0));
        checkOutput("rst_out_bundle", 160'(outB), 160'(0));
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("rst_release_in_ready", 160'(in_ready), 160'(1));

        // Streaming, one bundle per cycle.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, mkB(32'(4 * i)), 1'b1, 1'b0);
            checkOutput("stream_pc", 160'(outB.pc), 160'(4 * i));
            checkOutput("stream_occ", 160'(occupancy), 160'(1));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stream_empty", 160'(out_valid), 160'(0));

        // Stall into the skid entry and drain in order.
        applyStimulus(1'b1, mkB(32'h20), 1'b0, 1'b0);
        applyStimulus(1'b1, mkB(32'h24), 1'b0, 1'b0);
        checkOutput("skid_occ", 160'(occupancy), 160'(2));
        checkOutput("skid_in_ready", 160'(in_ready), 160'(0));
        checkOutput("skid_hold_pc", 160'(outB.pc), 160'(32'h20));
        applyStimulus(1'b1, mkB(32'h28), 1'b0, 1'b0);
        checkOutput("skid_still_pc", 160'(outB.pc), 160'(32'h20));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("drain_pc_24", 160'(outB.pc), 160'(32'h24));
        checkOutput("drain_in_ready", 160'(in_ready), 160'(1));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("drain_empty", 160'(occupancy), 160'(0));

        // Flush with both entries full and an input offered.
        b = mkB(32'h30); b.memWEn = 1'b1;
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        b = mkB(32'h34); b.memWEn = 1'b1;
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        checkOutput("preflush_occ", 160'(occupancy), 160'(2));
        applyStimulus(1'b1, mkB(32'h38), 1'b0, 1'b1);
        checkOutput("flush_valid", 160'(out_valid), 160'(0));
        checkOutput("flush_occ", 160'(occupancy), 160'(0));
        checkOutput("flush_wb_en", 160'(outB.wbEn), 160'(0));
        checkOutput("flush_mem_w_en", 160'(outB.memWEn), 160'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("flush_no_ghost", 160'(out_valid), 160'(0));

        // Value-2 select.
        b = mkB(32'h40); b.memREn = 1'b1; b.shiftOperand = 12'hABC;
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        checkOutput("select_ldr", 160'(out_select), 160'(1));
        checkOutput("select_shift", 160'(outB.shiftOperand), 160'(12'hABC));
        b = mkB(32'h44); b.exeCmd = 4'b0010;
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        checkOutput("select_add", 160'(out_select), 160'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

`ifdef ID_EXE_STALL_CNT_EN
        stall_cnt_clr = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        stall_cnt_clr = 1'b0;
        applyStimulus(1'b1, mkB(32'h50), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("stall_cnt_5", 160'(stall_cnt), 160'(5));
        stall_cnt_clr = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        stall_cnt_clr = 1'b0;
        checkOutput("stall_cnt_clr", 160'(stall_cnt), 160'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
`endif

        // Mixed traffic against the model.
        for (int i = 0; i < 300; i++) begin
            b = mkB($urandom);
            b.memREn = 1'($urandom);
            b.memWEn = 1'($urandom);
            b.wbEn   = 1'($urandom);
            rst = ($urandom_range(0, 60) != 0);
            applyStimulus(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 22) == 0));
        end
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
